// File: rtl/c_skip_seq_adder_ctrl.sv
// Sequential wide adder: one carry-skip adder of WIDTH bits is reused over CHUNKS chunks, LSB chunk first.
// Optional signed-overflow output is enabled by defining C_SKIP_SEQ_OVF_EN.

module c_skip_adder #(
  parameter int WIDTH = 26,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o
);
  localparam int NBLK = (WIDTH + BLK - 1) / BLK;

  logic [NBLK:0] cb;

  assign cb[0] = ci_i;

  // Ripple inside each block; a fully propagating block forwards its carry-in directly.
  for (genvar gb = 0; gb < NBLK; gb++) begin : g_blk
    localparam int LO = gb * BLK;
    localparam int NB = (WIDTH - LO < BLK) ? (WIDTH - LO) : BLK;

    logic [NB-1:0] p;
    logic [NB-1:0] g;
    logic [NB-1:0] sum;
    logic          rco;

    assign p = a_i[LO +: NB] ^ b_i[LO +: NB];
    assign g = a_i[LO +: NB] & b_i[LO +: NB];

    always_comb begin
      logic c;
      c   = cb[gb];
      sum = '0;
      for (int unsigned j = 0; j < NB; j++) begin
        sum[j] = p[j] ^ c;
        c      = g[j] | (p[j] & c);
      end
      rco = c;
    end

    assign s_o[LO +: NB] = sum;
    assign cb[gb+1]      = (&p) ? cb[gb] : rco;
  end

  assign co_o = cb[NBLK];
endmodule

module c_skip_seq_adder_ctrl #(
  parameter int WIDTH  = 26,
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*CHUNKS:1]   A,
  input  logic [WIDTH*CHUNKS:1]   B,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*CHUNKS:1]   S,
  output logic                    cout
`ifdef C_SKIP_SEQ_OVF_EN
  ,
  output logic                    ovf
`endif
);
  localparam int KW = $clog2(CHUNKS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q;
  logic [KW-1:0]     k_q;
  logic [WIDTH-1:0]  a_q [CHUNKS];
  logic [WIDTH-1:0]  b_q [CHUNKS];
  logic [WIDTH-1:0]  s_q [CHUNKS];
  logic [WIDTH-1:0]  a_in [CHUNKS];
  logic [WIDTH-1:0]  b_in [CHUNKS];
  logic              cin_q;
  logic              carry_q;
  logic              cout_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [WIDTH-1:0]  add_a;
  logic [WIDTH-1:0]  add_b;
  logic [WIDTH-1:0]  add_s;
  logic              add_ci;
  logic              add_co;
  logic              add_cmsb;
  logic              last_chunk;

  // Operands and result are held as chunk arrays so the active chunk is a plain array index.
  for (genvar gc = 0; gc < CHUNKS; gc++) begin : g_chunk
    assign a_in[gc]                    = A[WIDTH*gc+1 +: WIDTH];
    assign b_in[gc]                    = B[WIDTH*gc+1 +: WIDTH];
    assign S[WIDTH*gc+1 +: WIDTH]      = s_q[gc];
  end

  always_comb begin
    add_a      = a_q[k_q];
    add_b      = b_q[k_q];
    add_ci     = (k_q == '0) ? cin_q : carry_q;
    add_cmsb   = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_s[WIDTH-1];
    last_chunk = (k_q == KW'(CHUNKS - 1));
  end

  c_skip_adder #(
    .WIDTH (WIDTH),
    .BLK   (4)
  ) u_adder (
    .a_i  (add_a),
    .b_i  (add_b),
    .ci_i (add_ci),
    .s_o  (add_s),
    .co_o (add_co)
  );

`ifdef C_SKIP_SEQ_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      s_q         <= '{default: '0};
      cin_q       <= 1'b0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef C_SKIP_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a_in;
            b_q        <= b_in;
            cin_q      <= cin;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          s_q[k_q] <= add_s;
          carry_q  <= add_co;
          if (last_chunk) begin
            cout_q      <= add_co;
`ifdef C_SKIP_SEQ_OVF_EN
            ovf_q       <= add_cmsb ^ add_co;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign cout      = cout_q;

  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready_q == (state_q == IDLE));
  a_valid_done: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q == (state_q == DONE));
endmodule

// File: doc/c_skip_seq_adder_ctrl.md
C_SKIP_SEQ_ADDER_CTRL -- requirements
Module: c_skip_seq_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 26: chunk width in bits, equal to the width of the shared adder.
REQ-002 SHALL have parameter CHUNKS, default 4: number of chunks per operand; valid range is 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the requester presents operands.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 SHALL have port A, input, WIDTH*CHUNKS bits: operand A, bit 1 is the LSB ([WIDTH*CHUNKS:1] indexing).
REQ-008 SHALL have port B, input, WIDTH*CHUNKS bits: operand B, same indexing as A.
REQ-009 SHALL have port cin, input, 1 bit: carry-in to the full-width sum.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port S, output, WIDTH*CHUNKS bits: registered sum.
REQ-013 SHALL have port cout, output, 1 bit: registered carry-out of the full-width sum.

Function
REQ-014 SHALL instantiate exactly one C_Skip_A_26bit-class carry-skip adder of width WIDTH and time-share it across all chunks; no second adder is permitted.
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 SHALL drive in_ready=1 in IDLE only.
REQ-017 SHALL capture A, B and cin into internal registers in IDLE when in_valid=1, clear the chunk counter k to 0, and move to BUSY.
REQ-018 SHALL, in BUSY cycle k, feed chunk k (bits [WIDTH*(k+1):WIDTH*k+1]) of A and B to the adder, using carry-in = captured cin when k=0, else the registered carry from chunk k-1.
REQ-019 SHALL, at the end of each BUSY cycle, write the adder sum into S chunk k and the adder carry-out into the carry register.
REQ-020 SHALL leave BUSY after k=CHUNKS-1, load cout with the final carry and move to DONE; k SHALL NOT wrap while in BUSY.
REQ-021 SHALL give a latency from the accept edge to out_valid=1 of exactly CHUNKS cycles.
REQ-022 SHALL hold out_valid=1 in DONE, with S and cout stable, until out_ready=1.
REQ-023 SHALL return to IDLE on the edge where out_valid=1 and out_ready=1; in_ready=1 in the following cycle.
REQ-024 SHALL ignore in_valid outside IDLE; operands change during BUSY SHALL have no effect.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL keep S and cout unchanged in IDLE (last result retained); only chunks already written in BUSY may differ from the previous result.

Reset
REQ-027 SHALL, when rst_n=0, immediately force state=IDLE, k=0, carry register=0, S=0, cout=0, out_valid=0 and in_ready=1 (effective once rst_n deasserts).
REQ-028 SHALL abandon an in-flight BUSY or DONE operation when reset asserts mid-operation; no result is emitted after reset release.

Configuration
REQ-029 SHALL, when macro C_SKIP_SEQ_OVF_EN is defined, add output port ovf, 1 bit, registered: the XOR of the carry into and the carry out of the MSB of the final chunk (signed overflow), reset 0, valid with out_valid.
REQ-030 SHALL, when C_SKIP_SEQ_OVF_EN is undefined, have no ovf port and no associated logic.

Verification
REQ-031 SHALL cover: defaults, A=all ones (104 bits), B=0, cin=1 -> S=0, cout=1, out_valid exactly 4 cycles after accept.
REQ-032 SHALL cover: A=0x3FFFFFF (chunk 0 all ones), B=1, cin=0 -> S=0x4000000 (carry into chunk 1), cout=0.
REQ-033 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid, S and cout stable; in_ready=0 throughout; accept on out_ready=1, then in_ready=1 in the next cycle.
REQ-034 SHALL cover: rst_n pulsed low in BUSY cycle k=2 -> out_valid=0, S=0, cout=0, in_ready=1 after release; no out_valid pulse follows.
REQ-035 SHALL cover: in_valid toggled and operands changed during BUSY -> result matches the operands captured at the accept edge.
REQ-036 SHALL cover, with C_SKIP_SEQ_OVF_EN defined: A=0x7FF...F (MSB 0), B=1, cin=0 -> ovf=1, cout=0.
